// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch time counter.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_t;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // One BCD step: 9 rolls back to 0.
  function automatic logic [DIGIT_W-1:0] bcd_inc(input logic [DIGIT_W-1:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Button inputs and time/display outputs of the stopwatch counter.
interface stopwatch_counter_if;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic       Running;
  logic       Wrapped;
  logic [3:0] Digit0;
  logic [3:0] Digit1;
  logic [3:0] Digit2;
  logic [3:0] Digit3;
  logic [6:0] Segments0;
  logic [6:0] Segments1;
  logic [6:0] Segments2;
  logic [6:0] Segments3;

  modport master (
    output Start, Stop, Clear,
    input  Running, Wrapped, Digit0, Digit1, Digit2, Digit3,
    input  Segments0, Segments1, Segments2, Segments3
  );

  modport slave (
    input  Start, Stop, Clear,
    output Running, Wrapped, Digit0, Digit1, Digit2, Digit3,
    output Segments0, Segments1, Segments2, Segments3
  );
endinterface

// File: rtl/stopwatch_counter_seg7_encoder.sv
// BCD digit to active-low seven-segment pattern; codes above 9 show blank.
module seg7_encoder
  import stopwatch_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [6:0]         seg
);

  // Pure lookup, registered by the caller.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: button conditioning, run-control FSM, 10 ms timebase,
// four-digit BCD time (SS.hh) and registered seven-segment outputs.
//
//   state    | meaning
//   ST_IDLE  | time is zero, stopped
//   ST_RUN   | counting hundredths
//   ST_PAUSE | stopped, time and fractional tick preserved
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter logic [31:0] TickDiv = 32'd1000000
) (
  input  logic               Clock,
  input  logic               Reset_n,
  stopwatch_counter_if.slave bus
);

  logic [2:0] sync_start, sync_stop, sync_clear;
  logic       start_rise, stop_rise, clear_rise;

  sw_state_t   state;
  logic        running;
  logic        wrapped;
  logic [31:0] prescaler;
  logic        tick;
  logic        clear_now;

  logic [DIGIT_W-1:0] digit0, digit1, digit2, digit3;
  logic               carry1, carry2, carry3, wrap_now;
  logic [6:0]         seg_next0, seg_next1, seg_next2, seg_next3;
  logic [6:0]         seg0, seg1, seg2, seg3;

  // Three-flop shift per button; a rise is seen once s2 is high and s3 still low.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_start <= 3'b000;
      sync_stop  <= 3'b000;
      sync_clear <= 3'b000;
    end else begin
      sync_start <= {sync_start[1:0], bus.Start};
      sync_stop  <= {sync_stop[1:0],  bus.Stop};
      sync_clear <= {sync_clear[1:0], bus.Clear};
    end
  end

  assign start_rise = sync_start[1] & ~sync_start[2];
  assign stop_rise  = sync_stop[1]  & ~sync_stop[2];
  assign clear_rise = sync_clear[1] & ~sync_clear[2];

  assign clear_now = (state == ST_PAUSE) && clear_rise;
  assign tick      = (state == ST_RUN) && (prescaler == TickDiv - 32'd1);

  // Run-control FSM; Stop beats Start, Clear beats Start in PAUSE.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise && !stop_rise) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_rise) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (clear_rise) begin
            state <= ST_IDLE;
          end else if (start_rise && !stop_rise) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Timebase: counts only in RUN, holds in PAUSE so resume keeps the fraction.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      prescaler <= 32'd0;
    end else if (state == ST_RUN) begin
      prescaler <= tick ? 32'd0 : prescaler + 32'd1;
    end else if (state == ST_IDLE || clear_now) begin
      prescaler <= 32'd0;
    end
  end

  assign carry1   = tick   && (digit0 == 4'd9);
  assign carry2   = carry1 && (digit1 == 4'd9);
  assign carry3   = carry2 && (digit2 == 4'd9);
  assign wrap_now = carry3 && (digit3 == 4'd9);

  // BCD time chain with the one-cycle wrap pulse at 99.99 -> 00.00.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      digit0  <= '0;
      digit1  <= '0;
      digit2  <= '0;
      digit3  <= '0;
      wrapped <= 1'b0;
    end else begin
      wrapped <= wrap_now;
      if (clear_now) begin
        digit0 <= '0;
        digit1 <= '0;
        digit2 <= '0;
        digit3 <= '0;
      end else begin
        if (tick)   digit0 <= bcd_inc(digit0);
        if (carry1) digit1 <= bcd_inc(digit1);
        if (carry2) digit2 <= bcd_inc(digit2);
        if (carry3) digit3 <= bcd_inc(digit3);
      end
    end
  end

  seg7_encoder u_enc0 (.bcd(digit0), .seg(seg_next0));
  seg7_encoder u_enc1 (.bcd(digit1), .seg(seg_next1));
  seg7_encoder u_enc2 (.bcd(digit2), .seg(seg_next2));
  seg7_encoder u_enc3 (.bcd(digit3), .seg(seg_next3));

  // Segment registers, one cycle behind the digits.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      seg0 <= SEG_0;
      seg1 <= SEG_0;
      seg2 <= SEG_0;
      seg3 <= SEG_0;
    end else begin
      seg0 <= seg_next0;
      seg1 <= seg_next1;
      seg2 <= seg_next2;
      seg3 <= seg_next3;
    end
  end

  assign bus.Running   = running;
  assign bus.Wrapped   = wrapped;
  assign bus.Digit0    = digit0;
  assign bus.Digit1    = digit1;
  assign bus.Digit2    = digit2;
  assign bus.Digit3    = digit3;
  assign bus.Segments0 = seg0;
  assign bus.Segments1 = seg1;
  assign bus.Segments2 = seg2;
  assign bus.Segments3 = seg3;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: three instances with TickDiv 4, 2 and 10.
module tb_stopwatch_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v, stop_v, clear_v;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  stopwatch_counter_if if_a ();
  stopwatch_counter_if if_b ();
  stopwatch_counter_if if_c ();

  assign if_a.Start = start_v[0];
  assign if_a.Stop  = stop_v[0];
  assign if_a.Clear = clear_v[0];
  assign if_b.Start = start_v[1];
  assign if_b.Stop  = stop_v[1];
  assign if_b.Clear = clear_v[1];
  assign if_c.Start = start_v[2];
  assign if_c.Stop  = stop_v[2];
  assign if_c.Clear = clear_v[2];

  stopwatch_counter #(.TickDiv(32'd4))  u_a (.Clock(clk), .Reset_n(rst_n), .bus(if_a.slave));
  stopwatch_counter #(.TickDiv(32'd2))  u_b (.Clock(clk), .Reset_n(rst_n), .bus(if_b.slave));
  stopwatch_counter #(.TickDiv(32'd10)) u_c (.Clock(clk), .Reset_n(rst_n), .bus(if_c.slave));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse; returns just after the edge where the state reacts.
  task automatic press(input int d, input logic s, input logic p, input logic c);
    start_v[d] = s;
    stop_v[d]  = p;
    clear_v[d] = c;
    step(1);
    start_v[d] = 1'b0;
    stop_v[d]  = 1'b0;
    clear_v[d] = 1'b0;
    step(2);
  endtask

  initial begin
    rst_n   = 1'b0;
    start_v = 3'b111;
    stop_v  = 3'b000;
    clear_v = 3'b000;
    step(3);
    check_val("rst_running", 32'(if_a.Running), 32'd0);
    check_val("rst_digits", 32'({if_a.Digit3, if_a.Digit2, if_a.Digit1, if_a.Digit0}), 32'h0);
    check_val("rst_seg0", 32'(if_a.Segments0), 32'h40);
    check_val("rst_seg3", 32'(if_a.Segments3), 32'h40);
    start_v = 3'b000;
    step(1);
    rst_n = 1'b1;
    step(5);
    check_val("idle_after_rst", 32'(if_a.Running), 32'd0);

    // Start latency, TickDiv 4
    start_v[0] = 1'b1;
    step(1);
    start_v[0] = 1'b0;
    step(1);
    check_val("lat_edge2", 32'(if_a.Running), 32'd0);
    step(1);
    check_val("lat_edge3", 32'(if_a.Running), 32'd1);
    step(3);
    check_val("tick_early", 32'(if_a.Digit0), 32'd0);
    step(1);
    check_val("tick_first", 32'(if_a.Digit0), 32'd1);
    check_val("seg_lag", 32'(if_a.Segments0), 32'h40);
    step(1);
    check_val("seg_one", 32'(if_a.Segments0), 32'h79);

    // Clear in RUN ignored, then Start+Stop -> PAUSE, then Start+Clear -> IDLE
    press(0, 1'b0, 1'b0, 1'b1);
    check_val("clr_run_running", 32'(if_a.Running), 32'd1);
    check_val("clr_run_digit0", 32'(if_a.Digit0), 32'd2);
    press(0, 1'b1, 1'b1, 1'b0);
    check_val("startstop_running", 32'(if_a.Running), 32'd0);
    check_val("startstop_digit0", 32'(if_a.Digit0), 32'd2);
    check_val("startstop_presc", u_a.prescaler, 32'd3);
    press(0, 1'b1, 1'b0, 1'b1);
    check_val("startclr_running", 32'(if_a.Running), 32'd0);
    check_val("startclr_digits", 32'({if_a.Digit3, if_a.Digit2, if_a.Digit1, if_a.Digit0}), 32'h0);
    check_val("startclr_presc", u_a.prescaler, 32'd0);
    step(1);
    check_val("startclr_seg0", 32'(if_a.Segments0), 32'h40);

    // Pause/resume, TickDiv 10
    press(2, 1'b1, 1'b0, 1'b0);
    step(23);
    press(2, 1'b0, 1'b1, 1'b0);
    check_val("pause_running", 32'(if_c.Running), 32'd0);
    check_val("pause_presc", u_c.prescaler, 32'd6);
    check_val("pause_digits", 32'({if_c.Digit3, if_c.Digit2, if_c.Digit1, if_c.Digit0}), 32'h0002);
    step(50);
    check_val("hold_presc", u_c.prescaler, 32'd6);
    check_val("hold_digits", 32'({if_c.Digit3, if_c.Digit2, if_c.Digit1, if_c.Digit0}), 32'h0002);
    press(2, 1'b1, 1'b0, 1'b0);
    check_val("resume_running", 32'(if_c.Running), 32'd1);
    step(3);
    check_val("resume_presc9", u_c.prescaler, 32'd9);
    check_val("resume_before", 32'(if_c.Digit0), 32'd2);
    step(1);
    check_val("resume_tick", 32'(if_c.Digit0), 32'd3);
    press(2, 1'b0, 1'b1, 1'b0);
    check_val("stop2_presc", u_c.prescaler, 32'd3);
    press(2, 1'b0, 1'b0, 1'b1);
    check_val("clear_digits", 32'({if_c.Digit3, if_c.Digit2, if_c.Digit1, if_c.Digit0}), 32'h0);
    check_val("clear_presc", u_c.prescaler, 32'd0);
    check_val("clear_seg_lag", 32'(if_c.Segments0), 32'h30);
    step(1);
    check_val("clear_segs", 32'({if_c.Segments3, if_c.Segments2, if_c.Segments1, if_c.Segments0}),
              32'({7'h40, 7'h40, 7'h40, 7'h40}));

    // Carry and wrap, TickDiv 2
    press(1, 1'b1, 1'b0, 1'b0);
    step(1998);
    check_val("t_0999", 32'({if_b.Digit3, if_b.Digit2, if_b.Digit1, if_b.Digit0}), 32'h0999);
    step(2);
    check_val("t_1000", 32'({if_b.Digit3, if_b.Digit2, if_b.Digit1, if_b.Digit0}), 32'h1000);
    check_val("t_1000_seg3", 32'(if_b.Segments3), 32'h40);
    step(1);
    check_val("t_1000_seg3b", 32'(if_b.Segments3), 32'h79);
    step(17997);
    check_val("t_9999", 32'({if_b.Digit3, if_b.Digit2, if_b.Digit1, if_b.Digit0}), 32'h9999);
    check_val("t_9999_wrapped", 32'(if_b.Wrapped), 32'd0);
    step(2);
    check_val("wrap_digits", 32'({if_b.Digit3, if_b.Digit2, if_b.Digit1, if_b.Digit0}), 32'h0000);
    check_val("wrap_pulse", 32'(if_b.Wrapped), 32'd1);
    check_val("wrap_running", 32'(if_b.Running), 32'd1);
    step(1);
    check_val("wrap_pulse_end", 32'(if_b.Wrapped), 32'd0);
    step(1);
    check_val("after_wrap", 32'({if_b.Digit3, if_b.Digit2, if_b.Digit1, if_b.Digit0}), 32'h0001);
    step(1);
    check_val("after_wrap_seg0", 32'(if_b.Segments0), 32'h79);

    // Asynchronous reset mid-count, checked between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_running", 32'(if_b.Running), 32'd0);
    check_val("arst_digits", 32'({if_b.Digit3, if_b.Digit2, if_b.Digit1, if_b.Digit0}), 32'h0);
    check_val("arst_seg0", 32'(if_b.Segments0), 32'h40);
    check_val("arst_presc", u_b.prescaler, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
